// File: rtl/render_pkg.sv
// Shared types and constants for the per-frame render sequencer.
// Keeps the FSM encoding and framebuffer geometry in one place.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        DRAIN,
        SWAP
    } fsm_state_e;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int PIX_W_DEF = 12;
    localparam int Z_W_DEF   = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;
    typedef logic [Z_W_DEF-1:0]   depth_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Paired framebuffer / Z-buffer write bus: one strobe, address and data per buffer.
// Used both for the rasterizer's request and for the sequencer's muxed output.
interface frame_sequencer_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12,
    parameter int Z_W    = 8
);
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_pixel;
    logic              zb_we;
    logic [ADDR_W-1:0] zb_addr;
    logic [Z_W-1:0]    zb_data;

    modport master (
        output fb_we, fb_addr, fb_pixel,
        output zb_we, zb_addr, zb_data
    );

    modport slave (
        input fb_we, fb_addr, fb_pixel,
        input zb_we, zb_addr, zb_data
    );
endinterface

// File: rtl/clear_engine.sv
// Buffer-clear address generator: walks 0..FB_WORDS-1 while enabled.
// Any cycle without enable parks the counter at 0, so an aborted clear always restarts.
module clear_engine
    import render_pkg::*;
#(
    parameter int FB_WORDS = FB_W * FB_H,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    assign last = (addr == ADDR_W'(FB_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (!en || last) begin
            addr <= '0;
        end else begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: clear back buffers, launch geometry, wait for drain, swap on vsync.
// Owns the single FB/ZB write port, muxing the clear engine against rasterizer writes.
module frame_sequencer
    import render_pkg::*;
#(
    parameter int               FB_WORDS    = FB_W * FB_H,
    parameter int               ADDR_W      = 17,
    parameter int               PIX_W       = 12,
    parameter int               Z_W         = 8,
    parameter logic [PIX_W-1:0] CLEAR_PIXEL = '0,
    parameter logic [Z_W-1:0]   CLEAR_Z     = '1,
    parameter int               DRAIN_QUIET = 16,
    parameter int               TIMEOUT_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_auto,
    input  logic              i_vsync,
    input  logic              i_gem_busy,
    input  logic              i_fifo_empty,
    input  logic              i_tri_valid,
    input  logic              i_rast_busy,
    frame_sequencer_if.slave  rast,
    frame_sequencer_if.master fb_out,
    output logic              o_gem_start,
    output logic              o_buf_sel,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [3:0]        o_frame_idx,
    output logic              o_timeout,
    output logic              o_err
);

    localparam int QW = $clog2(DRAIN_QUIET + 1);

    fsm_state_e           state, state_nx;
    logic [ADDR_W-1:0]    clr_addr;
    logic                 clr_last;
    logic [QW-1:0]        quiet_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 pipe_idle;
    logic                 quiet_done;
    logic                 wd_tc;
    logic                 swap_now;

    clear_engine #(
        .FB_WORDS (FB_WORDS),
        .ADDR_W   (ADDR_W)
    ) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == CLEAR),
        .addr  (clr_addr),
        .last  (clr_last)
    );

    assign pipe_idle  = !i_gem_busy && i_fifo_empty && !i_tri_valid && !i_rast_busy;
    assign quiet_done = pipe_idle && (quiet_cnt == QW'(DRAIN_QUIET - 1));
    assign wd_tc      = (wd_cnt == '0);
    assign swap_now   = (state == SWAP) && i_vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = CLEAR;
            CLEAR:   if (clr_last) state_nx = LAUNCH;
            LAUNCH:  state_nx = DRAIN;
            DRAIN:   if (quiet_done || wd_tc) state_nx = SWAP;
            SWAP:    if (i_vsync) state_nx = i_auto ? CLEAR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign o_gem_start = (state == LAUNCH);
    assign o_busy      = (state != IDLE);

    // Watchdog is a down-counter reloaded to all-ones outside DRAIN; terminal count is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_cnt <= '0;
            wd_cnt    <= '0;
        end else if (state == DRAIN) begin
            quiet_cnt <= pipe_idle ? quiet_cnt + QW'(1) : '0;
            wd_cnt    <= wd_cnt - TIMEOUT_W'(1);
        end else begin
            quiet_cnt <= '0;
            wd_cnt    <= '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_timeout    <= 1'b0;
            o_err        <= 1'b0;
            o_buf_sel    <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_idx  <= '0;
        end else begin
            o_timeout    <= o_timeout | ((state == DRAIN) && wd_tc);
            o_err        <= o_err | ((state == CLEAR) && (rast.fb_we || rast.zb_we));
            o_frame_done <= swap_now;
            if (swap_now) begin
                o_buf_sel   <= ~o_buf_sel;
                o_frame_idx <= o_frame_idx + 4'd1;
            end
        end
    end

    // Registered write mux; rasterizer strobes during CLEAR are dropped (flagged via o_err).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_out.fb_we    <= 1'b0;
            fb_out.fb_addr  <= '0;
            fb_out.fb_pixel <= '0;
            fb_out.zb_we    <= 1'b0;
            fb_out.zb_addr  <= '0;
            fb_out.zb_data  <= '0;
        end else if (state == CLEAR) begin
            fb_out.fb_we    <= 1'b1;
            fb_out.fb_addr  <= clr_addr;
            fb_out.fb_pixel <= CLEAR_PIXEL;
            fb_out.zb_we    <= 1'b1;
            fb_out.zb_addr  <= clr_addr;
            fb_out.zb_data  <= CLEAR_Z;
        end else begin
            fb_out.fb_we    <= rast.fb_we;
            fb_out.fb_addr  <= rast.fb_addr;
            fb_out.fb_pixel <= rast.fb_pixel;
            fb_out.zb_we    <= rast.zb_we;
            fb_out.zb_addr  <= rast.zb_addr;
            fb_out.zb_data  <= rast.zb_data;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer, built with a small buffer and short watchdog
// so every scenario (including the watchdog firing and the frame counter wrap) runs quickly.
module tb_frame_sequencer;
    import render_pkg::*;

    localparam int FB_WORDS    = 64;
    localparam int ADDR_W      = 17;
    localparam int DRAIN_QUIET = 16;
    localparam int TIMEOUT_W   = 8;

    typedef struct packed {
        logic              fb_we;
        logic [ADDR_W-1:0] fb_addr;
        pixel_t            fb_pixel;
        logic              zb_we;
        logic [ADDR_W-1:0] zb_addr;
        depth_t            zb_data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0, i_auto = 1'b0, i_vsync = 1'b1;
    logic       i_gem_busy = 1'b0, i_fifo_empty = 1'b1, i_tri_valid = 1'b0, i_rast_busy = 1'b0;
    logic       o_gem_start, o_buf_sel, o_busy, o_frame_done, o_timeout, o_err;
    logic [3:0] o_frame_idx;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  gem_cyc;
    wr_t exp_q[$];

    frame_sequencer_if #(.ADDR_W(ADDR_W), .PIX_W(12), .Z_W(8)) rast_if ();
    frame_sequencer_if #(.ADDR_W(ADDR_W), .PIX_W(12), .Z_W(8)) out_if ();

    frame_sequencer #(
        .FB_WORDS    (FB_WORDS),
        .ADDR_W      (ADDR_W),
        .PIX_W       (12),
        .Z_W         (8),
        .CLEAR_PIXEL (12'h000),
        .CLEAR_Z     (8'hFF),
        .DRAIN_QUIET (DRAIN_QUIET),
        .TIMEOUT_W   (TIMEOUT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_auto       (i_auto),
        .i_vsync      (i_vsync),
        .i_gem_busy   (i_gem_busy),
        .i_fifo_empty (i_fifo_empty),
        .i_tri_valid  (i_tri_valid),
        .i_rast_busy  (i_rast_busy),
        .rast         (rast_if),
        .fb_out       (out_if),
        .o_gem_start  (o_gem_start),
        .o_buf_sel    (o_buf_sel),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_frame_idx  (o_frame_idx),
        .o_timeout    (o_timeout),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    // Every write seen on the muxed port must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && (out_if.fb_we || out_if.zb_we)) begin
            wr_t got, e;
            got.fb_we    = out_if.fb_we;
            got.fb_addr  = out_if.fb_addr;
            got.fb_pixel = out_if.fb_pixel;
            got.zb_we    = out_if.zb_we;
            got.zb_addr  = out_if.zb_addr;
            got.zb_data  = out_if.zb_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got fb_addr %0d pix %h zb_addr %0d z %h, expected none",
                         got.fb_addr, got.fb_pixel, got.zb_addr, got.zb_data);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL write_data: got we %b/%b addr %0d/%0d data %h/%h, expected we %b/%b addr %0d/%0d data %h/%h",
                             got.fb_we, got.zb_we, got.fb_addr, got.zb_addr, got.fb_pixel, got.zb_data,
                             e.fb_we, e.zb_we, e.fb_addr, e.zb_addr, e.fb_pixel, e.zb_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        wr_t e;
        for (int a = 0; a < FB_WORDS; a++) begin
            e.fb_we    = 1'b1;
            e.fb_addr  = ADDR_W'(a);
            e.fb_pixel = 12'h000;
            e.zb_we    = 1'b1;
            e.zb_addr  = ADDR_W'(a);
            e.zb_data  = 8'hFF;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(output int s);
        tick();
        i_start = 1'b1;
        s = cyc;
        push_clear();
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_gem(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_gem_start) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_frame_done) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++;
        if ({o_busy, o_gem_start, o_buf_sel, o_frame_done, o_timeout, o_err, out_if.fb_we, out_if.zb_we} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 00000000",
                     {o_busy, o_gem_start, o_buf_sel, o_frame_done, o_timeout, o_err, out_if.fb_we, out_if.zb_we});
        end
        checks++;
        if (o_frame_idx !== 4'd0 || out_if.fb_addr !== '0 || out_if.zb_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got idx %0d fb_addr %0d zb_data %h, expected 0 0 00",
                     o_frame_idx, out_if.fb_addr, out_if.zb_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clear_launch();
        int s, l;
        start_frame(s);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_clear: got %b, expected 1", o_busy);
        end
        wait_gem(l);
        gem_cyc = l;
        checks++;
        if (l - s !== FB_WORDS + 1) begin
            errors++;
            $display("FAIL launch_latency: got %0d cycles, expected %0d", l - s, FB_WORDS + 1);
        end
        @(negedge clk);
        checks++;
        if (o_gem_start !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL launch_pulse: got gem_start %b pending writes %0d, expected 0 and 0",
                     o_gem_start, exp_q.size());
        end
    endtask

    task automatic test_drain_quiet();
        int d;
        wait_done(100, d);
        checks++;
        if (d - gem_cyc !== DRAIN_QUIET + 2) begin
            errors++;
            $display("FAIL quiet_drain: got frame_done %0d cycles after launch, expected %0d",
                     d - gem_cyc, DRAIN_QUIET + 2);
        end
        checks++;
        if (o_buf_sel !== 1'b1 || o_frame_idx !== 4'd1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL first_swap: got buf_sel %b idx %0d busy %b, expected 1 1 0",
                     o_buf_sel, o_frame_idx, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b, expected 0", o_frame_done);
        end
    endtask

    task automatic test_quiet_restart();
        int s, l, d;
        start_frame(s);
        wait_gem(l);
        for (int c = 1; c <= 14; c++) begin
            tick();
            i_rast_busy = (c >= 11 && c <= 13);
        end
        wait_done(100, d);
        checks++;
        if (d - l !== 10 + 3 + DRAIN_QUIET + 2) begin
            errors++;
            $display("FAIL quiet_restart: got frame_done %0d cycles after launch, expected %0d",
                     d - l, 10 + 3 + DRAIN_QUIET + 2);
        end
        checks++;
        if (o_buf_sel !== 1'b0 || o_frame_idx !== 4'd2) begin
            errors++;
            $display("FAIL second_swap: got buf_sel %b idx %0d, expected 0 2", o_buf_sel, o_frame_idx);
        end
    endtask

    task automatic test_err_passthrough();
        int s, l, d;
        wr_t e;
        i_gem_busy = 1'b1;
        start_frame(s);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %b, expected 0", o_err);
        end
        tick();
        rast_if.fb_we    = 1'b1;
        rast_if.fb_addr  = 17'd500;
        rast_if.fb_pixel = 12'hABC;
        tick();
        rast_if.fb_we = 1'b0;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b, expected 1", o_err);
        end
        wait_gem(l);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b, expected 1", o_err);
        end
        tick();
        rast_if.fb_we    = 1'b1;
        rast_if.fb_addr  = 17'd500;
        rast_if.fb_pixel = 12'hABC;
        rast_if.zb_we    = 1'b1;
        rast_if.zb_addr  = 17'd7;
        rast_if.zb_data  = 8'h5A;
        e.fb_we = 1'b1; e.fb_addr = 17'd500; e.fb_pixel = 12'hABC;
        e.zb_we = 1'b1; e.zb_addr = 17'd7;   e.zb_data  = 8'h5A;
        exp_q.push_back(e);
        @(negedge clk);
        checks++;
        if (out_if.fb_we !== 1'b0) begin
            errors++;
            $display("FAIL pass_latency_early: got fb_we %b, expected 0", out_if.fb_we);
        end
        tick();
        rast_if.fb_we = 1'b0;
        rast_if.zb_we = 1'b0;
        @(negedge clk);
        checks++;
        if (out_if.fb_we !== 1'b1 || out_if.fb_addr !== 17'd500 || out_if.fb_pixel !== 12'hABC) begin
            errors++;
            $display("FAIL pass_through: got we %b addr %0d pix %h, expected 1 500 abc",
                     out_if.fb_we, out_if.fb_addr, out_if.fb_pixel);
        end
        i_gem_busy = 1'b0;
        wait_done(100, d);
        checks++;
        if (d < 0 || o_frame_idx !== 4'd3) begin
            errors++;
            $display("FAIL third_swap: got done_cycle %0d idx %0d, expected done and 3", d, o_frame_idx);
        end
    endtask

    task automatic test_auto_wrap();
        int s, d;
        rst_n = 1'b0;
        exp_q.delete();
        #17;
        @(negedge clk);
        rst_n = 1'b1;
        i_auto = 1'b1;
        start_frame(s);
        for (int f = 1; f <= 16; f++) begin
            wait_done(300, d);
            if (f < 16) push_clear();
            checks++;
            if (d < 0 || o_frame_idx !== 4'(f)) begin
                errors++;
                $display("FAIL auto_frame_idx: frame %0d got idx %0d done_cycle %0d, expected idx %0d",
                         f, o_frame_idx, d, f % 16);
            end
            if (f == 15) begin
                tick();
                i_auto = 1'b0;
            end
        end
        checks++;
        if (o_busy !== 1'b0 || o_buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL auto_stop: got busy %b buf_sel %b, expected 0 0", o_busy, o_buf_sel);
        end
    endtask

    task automatic test_timeout();
        int s, l, t, d;
        i_gem_busy = 1'b1;
        start_frame(s);
        wait_gem(l);
        t = -1;
        d = -1;
        for (int i = 0; i < 400 && d < 0; i++) begin
            @(negedge clk);
            if (o_timeout && t < 0) t = cyc;
            if (o_frame_done) d = cyc;
        end
        i_gem_busy = 1'b0;
        checks++;
        if (t - l !== (1 << TIMEOUT_W) + 1) begin
            errors++;
            $display("FAIL timeout_time: got %0d cycles after launch, expected %0d", t - l, (1 << TIMEOUT_W) + 1);
        end
        checks++;
        if (d - l !== (1 << TIMEOUT_W) + 2 || o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_swap: got done %0d cycles after launch timeout %b, expected %0d and 1",
                     d - l, o_timeout, (1 << TIMEOUT_W) + 2);
        end
    endtask

    task automatic test_reset_mid_clear();
        int s, l;
        start_frame(s);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_buf_sel, o_timeout, o_err, out_if.fb_we, out_if.zb_we, o_frame_idx} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset: got busy %b buf %b to %b err %b we %b/%b idx %0d, expected all 0",
                     o_busy, o_buf_sel, o_timeout, o_err, out_if.fb_we, out_if.zb_we, o_frame_idx);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(s);
        wait_gem(l);
        checks++;
        if (l - s !== FB_WORDS + 1) begin
            errors++;
            $display("FAIL restart_clear: got %0d cycles, expected %0d", l - s, FB_WORDS + 1);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_pending: got %0d pending writes, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rast_if.fb_we = 1'b0; rast_if.fb_addr = '0; rast_if.fb_pixel = '0;
        rast_if.zb_we = 1'b0; rast_if.zb_addr = '0; rast_if.zb_data  = '0;
        test_reset();
        test_clear_launch();
        test_drain_quiet();
        test_quiet_restart();
        test_err_passthrough();
        test_auto_wrap();
        test_timeout();
        test_reset_mid_clear();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
